fir_coe_bank_loader: RTL and testbench

- Multi-channel, double-buffered FIR coefficient loader.
- Accepts a framed coefficient stream (sop/eop) tagged with a channel number into per-channel shadow banks, then checks each frame for exact length.
- On a masked commit pulse, atomically copies validated shadow banks and decimation words into the active outputs that feed the FIR datapaths.
- Single clock domain; sits between the config register/stream interface and CH_NUM FIR filter instances.

---
 rtl/fir_coe_bank_loader.sv | 173 +++++++++++++++++
 tb/tb_fir_coe_bank_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coe_bank_loader.sv
// Double-buffered multi-channel FIR coefficient loader: a framed stream fills per-channel
// shadow banks, and a masked commit copies validated banks and decimation words to the active outputs.
module fir_coe_bank_loader #(
    parameter int CH_NUM   = 4,
    parameter int CH_WDTH  = 2,
    parameter int COE_NUM  = 51,
    parameter int COE_WDTH = 29,
    parameter int SYM      = 1,
    parameter int COE_LEN  = (SYM != 0) ? (COE_NUM + 1) / 2 : COE_NUM,
    parameter int DEC_WDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 coe_vld,
    input  logic                                 coe_sop,
    input  logic                                 coe_eop,
    input  logic [CH_WDTH-1:0]                   coe_ch,
    input  logic [COE_WDTH-1:0]                  coe_din,
    input  logic [DEC_WDTH-1:0]                  coe_fir_dec,
    input  logic                                 coe_load,
    input  logic [CH_NUM-1:0]                    coe_load_mask,
    output logic                                 load_busy,
    output logic                                 load_done,
    output logic [CH_NUM-1:0]                    load_err,
    output logic [CH_NUM-1:0]                    coe_upd,
    output logic [CH_NUM*DEC_WDTH-1:0]           fir_dec,
    output logic [CH_NUM*COE_LEN*COE_WDTH-1:0]   coe_arr
);

    localparam int               IDX_W = $clog2(COE_LEN + 1);
    localparam logic [IDX_W-1:0] LEN_C = IDX_W'(COE_LEN);

    typedef enum logic {IDLE, WR} state_e;

    state_e                             state_q, state_d;
    logic [CH_WDTH-1:0]                 ch_q, ch_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               ovf_q, ovf_d;
    logic [CH_NUM-1:0]                  valid_q, valid_d;
    logic [CH_NUM-1:0]                  err_q, err_d;
    logic [CH_NUM-1:0]                  upd_q, upd_d;
    logic                               done_q, done_d;
    logic                               pending_q, pending_d;
    logic [CH_NUM-1:0]                  pmask_q, pmask_d;
    logic [CH_NUM-1:0]                  commit_mask;
    logic                               exec;
    logic                               wr_en;
    logic [CH_WDTH-1:0]                 wr_ch;
    logic [IDX_W-1:0]                   wr_idx;
    logic [CH_NUM*DEC_WDTH-1:0]         fir_dec_q;
    logic [CH_NUM*COE_LEN*COE_WDTH-1:0] coe_arr_q;
    logic [COE_WDTH-1:0]                shadow_q [CH_NUM][COE_LEN];

    // Channel numbers at or above CH_NUM decode to an all-zero vector, so such frames touch nothing.
    function automatic logic [CH_NUM-1:0] ch_onehot(input logic [CH_WDTH-1:0] c);
        logic [CH_NUM-1:0] oh;
        oh = '0;
        for (int k = 0; k < CH_NUM; k++) oh[k] = (c == CH_WDTH'(k));
        return oh;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch can be inferred.
        state_d   = state_q;
        ch_d      = ch_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        err_d     = err_q;
        wr_en     = 1'b0;
        wr_ch     = ch_q;
        wr_idx    = idx_q;
        pending_d = pending_q;
        pmask_d   = pmask_q;
        upd_d     = '0;
        done_d    = 1'b0;

        if (coe_vld) begin
            if (coe_sop) begin
                if (state_q == WR) err_d = err_d | ch_onehot(ch_q);
                ch_d    = coe_ch;
                idx_d   = IDX_W'(1);
                ovf_d   = 1'b0;
                wr_en   = 1'b1;
                wr_ch   = coe_ch;
                wr_idx  = '0;
                valid_d = valid_d & ~ch_onehot(coe_ch);
                state_d = WR;
            end else if (state_q == WR) begin
                if (idx_q < LEN_C) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            if (coe_eop && (coe_sop || state_q == WR)) begin
                state_d = IDLE;
                if (idx_d == LEN_C && !ovf_d) begin
                    valid_d = valid_d | ch_onehot(ch_d);
                    err_d   = err_d & ~ch_onehot(ch_d);
                end else begin
                    err_d   = err_d | ch_onehot(ch_d);
                end
            end
        end

        // A commit only executes while no frame is open; otherwise it is parked with its mask.
        commit_mask = pmask_q | (coe_load ? coe_load_mask : '0);
        exec        = (state_q == IDLE) && (pending_q || coe_load);
        if (exec) begin
            pending_d = 1'b0;
            pmask_d   = '0;
            done_d    = 1'b1;
            upd_d     = commit_mask & valid_q;
            err_d     = err_d | (commit_mask & ~valid_q);
        end else if (coe_load) begin
            pending_d = 1'b1;
            pmask_d   = commit_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= '0;
            err_q     <= '0;
            upd_q     <= '0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
            pmask_q   <= '0;
            fir_dec_q <= '0;
            coe_arr_q <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
            done_q    <= done_d;
            pending_q <= pending_d;
            pmask_q   <= pmask_d;
            for (int k = 0; k < CH_NUM; k++) begin
                if (upd_d[k]) begin
                    fir_dec_q[k*DEC_WDTH +: DEC_WDTH] <= coe_fir_dec;
                    for (int i = 0; i < COE_LEN; i++)
                        coe_arr_q[(k*COE_LEN+i)*COE_WDTH +: COE_WDTH] <= shadow_q[k][i];
                end
            end
        end
    end

    // NOTE: shadow storage is left unreset; valid_q gates every use of its contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < CH_NUM; k++)
            for (int i = 0; i < COE_LEN; i++)
                if (wr_en && wr_ch == CH_WDTH'(k) && wr_idx == IDX_W'(i))
                    shadow_q[k][i] <= coe_din;
    end

    assign load_busy = pending_q;
    assign load_done = done_q;
    assign load_err  = err_q;
    assign coe_upd   = upd_q;
    assign fir_dec   = fir_dec_q;
    assign coe_arr   = coe_arr_q;

endmodule

// File: tb/tb_fir_coe_bank_loader.sv
// Directed bench: a table of frame+commit records on the default configuration, hand sequences for
// pending commits, mid-frame sop, and a SYM=0 single-channel instance with reset mid-frame.
module tb_fir_coe_bank_loader;

    localparam int CH_NUM   = 4;
    localparam int CH_WDTH  = 2;
    localparam int COE_WDTH = 29;
    localparam int DEC_WDTH = 32;
    localparam int COE_LEN  = 26;
    localparam int S_LEN    = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                               rst, vld, sop, eop, load, busy, done;
    logic [CH_WDTH-1:0]                 ch;
    logic [COE_WDTH-1:0]                din;
    logic [DEC_WDTH-1:0]                dec;
    logic [CH_NUM-1:0]                  mask, err, upd;
    logic [CH_NUM*DEC_WDTH-1:0]         fir_dec;
    logic [CH_NUM*COE_LEN*COE_WDTH-1:0] coe_arr;

    logic                               s_rst, s_vld, s_sop, s_eop, s_load, s_busy, s_done;
    logic [0:0]                         s_ch, s_mask, s_err, s_upd;
    logic [COE_WDTH-1:0]                s_din;
    logic [DEC_WDTH-1:0]                s_dec, s_fir_dec;
    logic [S_LEN*COE_WDTH-1:0]          s_coe_arr;

    fir_coe_bank_loader #(.CH_NUM(4), .CH_WDTH(2), .COE_NUM(51), .COE_WDTH(29), .SYM(1), .DEC_WDTH(32)) u_dut (
        .clk(clk), .rst(rst), .coe_vld(vld), .coe_sop(sop), .coe_eop(eop), .coe_ch(ch), .coe_din(din),
        .coe_fir_dec(dec), .coe_load(load), .coe_load_mask(mask), .load_busy(busy), .load_done(done),
        .load_err(err), .coe_upd(upd), .fir_dec(fir_dec), .coe_arr(coe_arr)
    );

    fir_coe_bank_loader #(.CH_NUM(1), .CH_WDTH(1), .COE_NUM(7), .COE_WDTH(29), .SYM(0), .DEC_WDTH(32)) u_sym0 (
        .clk(clk), .rst(s_rst), .coe_vld(s_vld), .coe_sop(s_sop), .coe_eop(s_eop), .coe_ch(s_ch), .coe_din(s_din),
        .coe_fir_dec(s_dec), .coe_load(s_load), .coe_load_mask(s_mask), .load_busy(s_busy), .load_done(s_done),
        .load_err(s_err), .coe_upd(s_upd), .fir_dec(s_fir_dec), .coe_arr(s_coe_arr)
    );

    typedef struct {
        int         ch;
        int         nwords;
        int         base;
        logic [3:0] mask;
        int         dec;
        logic [3:0] exp_upd;
        logic [3:0] exp_err;
    } vec_t;

    vec_t tbl [8];
    int   n_vec = 0;
    int   n_err = 0;
    int   clean_base [CH_NUM];
    int   act_base   [CH_NUM];
    int   act_dec    [CH_NUM];
    bit   act_set    [CH_NUM];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_word(input int c, input bit s, input bit e, input int d);
        @(negedge clk);
        vld = 1'b1; sop = s; eop = e; ch = CH_WDTH'(c); din = COE_WDTH'(d);
    endtask

    task automatic send_frame(input int c, input int n, input int base);
        for (int i = 0; i < n; i++) drive_word(c, i == 0, i == n - 1, base + i);
        @(negedge clk);
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic check_banks(input string tag);
        for (int k = 0; k < CH_NUM; k++) begin
            check($sformatf("%s fir_dec[%0d]", tag, k), 64'(fir_dec[k*DEC_WDTH +: DEC_WDTH]),
                  act_set[k] ? 64'(act_dec[k]) : 64'd0);
            for (int i = 0; i < COE_LEN; i++)
                check($sformatf("%s coe_arr[%0d][%0d]", tag, k, i),
                      64'(coe_arr[(k*COE_LEN+i)*COE_WDTH +: COE_WDTH]),
                      act_set[k] ? 64'(act_base[k] + i) : 64'd0);
        end
    endtask

    task automatic commit_and_check(input logic [3:0] m, input int d, input logic [3:0] exp_upd,
                                    input logic [3:0] exp_err, input string tag);
        load = 1'b1; mask = m; dec = DEC_WDTH'(d);
        @(negedge clk);
        load = 1'b0; mask = '0;
        check({tag, " load_done"}, 64'(done), 64'd1);
        check({tag, " load_busy"}, 64'(busy), 64'd0);
        check({tag, " coe_upd"}, 64'(upd), 64'(exp_upd));
        check({tag, " load_err"}, 64'(err), 64'(exp_err));
        for (int k = 0; k < CH_NUM; k++)
            if (exp_upd[k]) begin
                act_set[k] = 1'b1; act_base[k] = clean_base[k]; act_dec[k] = d;
            end
        check_banks(tag);
        @(negedge clk);
        check({tag, " load_done drop"}, 64'(done), 64'd0);
        check({tag, " coe_upd drop"}, 64'(upd), 64'd0);
    endtask

    task automatic check_sym0(input string tag, input bit set, input int base, input int d);
        check({tag, " fir_dec"}, 64'(s_fir_dec), set ? 64'(d) : 64'd0);
        for (int i = 0; i < S_LEN; i++)
            check($sformatf("%s coe_arr[%0d]", tag, i), 64'(s_coe_arr[i*COE_WDTH +: COE_WDTH]),
                  set ? 64'(base + i) : 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vld = 1'b0; sop = 1'b0; eop = 1'b0; ch = '0; din = '0; dec = '0; load = 1'b0; mask = '0;
        s_rst = 1'b1; s_vld = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_ch = '0; s_din = '0; s_dec = '0;
        s_load = 1'b0; s_mask = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            clean_base[k] = 0; act_base[k] = 0; act_dec[k] = 0; act_set[k] = 1'b0;
        end

        //          ch  words base   mask     dec  exp_upd  exp_err
        tbl[0] = '{2, 26,   1,   4'b0100,  8, 4'b0100, 4'b0000};
        tbl[1] = '{1, 25,   100, 4'b0010,  9, 4'b0000, 4'b0010};
        tbl[2] = '{0, 28,   200, 4'b0000,  0, 4'b0000, 4'b0011};
        tbl[3] = '{0, 26,   300, 4'b0001,  5, 4'b0001, 4'b0010};
        tbl[4] = '{1, 26,   400, 4'b0011,  7, 4'b0011, 4'b0000};
        tbl[5] = '{3, 26,   500, 4'b1100,  3, 4'b1100, 4'b0000};
        tbl[6] = '{2, 1,    600, 4'b0100,  4, 4'b0000, 4'b0100};
        tbl[7] = '{2, 26,   700, 4'b1111, 11, 4'b1111, 4'b0000};

        repeat (2) @(negedge clk);
        rst = 1'b0; s_rst = 1'b0;
        @(negedge clk);
        check("reset load_busy", 64'(busy), 64'd0);
        check("reset load_done", 64'(done), 64'd0);
        check("reset load_err", 64'(err), 64'd0);
        check("reset coe_upd", 64'(upd), 64'd0);
        check_banks("reset");

        for (int r = 0; r < 8; r++) begin
            send_frame(tbl[r].ch, tbl[r].nwords, tbl[r].base);
            if (tbl[r].nwords == COE_LEN) clean_base[tbl[r].ch] = tbl[r].base;
            commit_and_check(tbl[r].mask, tbl[r].dec, tbl[r].exp_upd, tbl[r].exp_err,
                             $sformatf("vec%0d", r));
        end

        // Commit requested mid-frame on ch3, a second request ORs in ch0.
        dec = 32'd21;
        for (int i = 0; i < COE_LEN; i++) begin
            drive_word(3, i == 0, i == COE_LEN - 1, 800 + i);
            if (i == 10) check("pend busy mid-frame", 64'(busy), 64'd1);
            load = (i == 9) || (i == 14);
            mask = (i == 9) ? 4'b1000 : (i == 14) ? 4'b0001 : 4'b0000;
        end
        clean_base[3] = 800;
        @(negedge clk);
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
        check("pend busy after eop", 64'(busy), 64'd1);
        check("pend done early", 64'(done), 64'd0);
        @(negedge clk);
        check("pend load_done", 64'(done), 64'd1);
        check("pend load_busy", 64'(busy), 64'd0);
        check("pend coe_upd", 64'(upd), 64'(4'b1001));
        check("pend load_err", 64'(err), 64'd0);
        act_set[3] = 1'b1; act_base[3] = 800; act_dec[3] = 21;
        act_set[0] = 1'b1; act_base[0] = 300; act_dec[0] = 21;
        check_banks("pend");

        // sop for ch1 aborts an open ch0 frame.
        for (int i = 0; i < 10; i++) drive_word(0, i == 0, 1'b0, 900 + i);
        for (int i = 0; i < COE_LEN; i++) begin
            drive_word(1, i == 0, i == COE_LEN - 1, 1000 + i);
            if (i == 1) check("abort load_err", 64'(err), 64'(4'b0001));
        end
        @(negedge clk);
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
        clean_base[1] = 1000;
        commit_and_check(4'b0011, 30, 4'b0010, 4'b0001, "abort");

        // SYM=0 single channel: clean 7-word frame, then reset mid-frame with a commit pending.
        for (int i = 0; i < S_LEN; i++) begin
            @(negedge clk);
            s_vld = 1'b1; s_sop = (i == 0); s_eop = (i == S_LEN - 1); s_din = COE_WDTH'(50 + i);
        end
        @(negedge clk);
        s_vld = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_load = 1'b1; s_mask = 1'b1; s_dec = 32'd66;
        @(negedge clk);
        s_load = 1'b0;
        check("sym0 load_done", 64'(s_done), 64'd1);
        check("sym0 coe_upd", 64'(s_upd), 64'd1);
        check("sym0 load_err", 64'(s_err), 64'd0);
        check_sym0("sym0", 1'b1, 50, 66);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) check("sym0 busy pending", 64'(s_busy), 64'd1);
            s_vld = 1'b1; s_sop = (i == 0); s_eop = 1'b0; s_din = COE_WDTH'(70 + i);
            s_load = (i == 1);
        end
        @(negedge clk);
        s_vld = 1'b0; s_sop = 1'b0; s_load = 1'b0; s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        check("sym0 rst busy", 64'(s_busy), 64'd0);
        check("sym0 rst done", 64'(s_done), 64'd0);
        check("sym0 rst err", 64'(s_err), 64'd0);
        check("sym0 rst upd", 64'(s_upd), 64'd0);
        check_sym0("sym0 rst", 1'b0, 0, 0);
        @(negedge clk);
        check("sym0 no partial commit", 64'(s_done), 64'd0);
        s_load = 1'b1; s_mask = 1'b1; s_dec = 32'd77;
        @(negedge clk);
        s_load = 1'b0;
        check("sym0 post-rst done", 64'(s_done), 64'd1);
        check("sym0 post-rst upd", 64'(s_upd), 64'd0);
        check("sym0 post-rst err", 64'(s_err), 64'd1);
        check_sym0("sym0 post-rst", 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
